// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : memory_arbiter
//  Purpose  : Shares one single-port RAM between the instruction-fetch port
//             and the data-memory port of the pipelined CPU. Accesses are
//             serialised through a fixed-latency access FSM. Data has
//             priority over fetch, and a starvation guard forces a fetch
//             after STARVE_MAX consecutive data completions while fetch is
//             waiting. iwait/dwait feed the hazard unit's freeze logic.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LAT         RAM access latency in cycles (>= 1)
//    STARVE_MAX  data completions tolerated while fetch waits (>= 1)
//  Ports
//    CLK, nRST           clock, synchronous active-low reset
//    iREN, iaddr         instruction read request and address
//    iload, iwait        instruction read data and stall
//    dREN, dWEN          data read / write request (write wins if both)
//    daddr, dstore       data address and write value
//    dload, dwait        data read data and stall
//    ramREN, ramWEN      RAM read / write enables
//    ramaddr, ramstore   RAM address and write data
//    ramload             RAM read data, valid on the LAT-th access cycle
// ============================================================================
module memory_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  localparam int CW = $clog2(LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(LAT);
  localparam logic [CW-1:0] CNT_FIRST  = CW'(1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_INSTR = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q,   addr_d;
  logic [31:0]   wdata_q,  wdata_d;
  logic          wr_q,     wr_d;

  logic w_dreq;
  logic w_busy;
  logic w_in_data;
  logic w_in_instr;
  logic w_last;
  logic w_own_req;
  logic w_d_done;
  logic w_i_done;
  logic w_abort;
  logic w_arb;
  logic w_force_i;

  assign w_dreq = dREN | dWEN;

  // Holding reset makes the arbiter look idle immediately, even before the
  // first sampling edge has cleared the state register.
  assign w_busy     = nRST & (state_q != ST_IDLE);
  assign w_in_data  = w_busy & (state_q == ST_DATA);
  assign w_in_instr = w_busy & (state_q == ST_INSTR);
  assign w_last     = w_busy & (cnt_q == CNT_LAST);

  // The owner must keep requesting; dropping the request aborts the access.
  assign w_own_req = (w_in_data & w_dreq) | (w_in_instr & iREN);
  assign w_abort   = w_busy & ~w_own_req;

  // A completion only counts while the owner still asks for it.
  assign w_d_done = w_last & w_in_data  & w_dreq;
  assign w_i_done = w_last & w_in_instr & iREN;

  // Arbitrate when idle, in a completion cycle, or after a withdrawal.
  assign w_arb = ~w_busy | w_last | w_abort;

  // Starvation counter next value.
  always_comb begin
    starve_d = starve_q;
    if (!iREN || w_i_done) begin
      starve_d = '0;
    end else if (w_d_done && (starve_q != STARVE_TOP)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // The guard looks at the updated count so that the completion which
  // reaches STARVE_MAX hands the very next slot to fetch.
  assign w_force_i = iREN & (starve_d == STARVE_TOP);

  // Access FSM next state and owner latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    if (w_arb) begin
      if (w_dreq && !w_force_i) begin
        state_d = ST_DATA;
        cnt_d   = CNT_FIRST;
        addr_d  = daddr;
        wdata_d = dstore;
        wr_d    = dWEN;
      end else if (iREN) begin
        state_d = ST_INSTR;
        cnt_d   = CNT_FIRST;
        addr_d  = iaddr;
        wdata_d = '0;
        wr_d    = 1'b0;
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        addr_d  = '0;
        wdata_d = '0;
        wr_d    = 1'b0;
      end
    end else begin
      // Mid-access: cnt never passes LAT because LAT forces arbitration.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
    end
  end

  // RAM side is driven only from the latched owner values.
  assign ramREN   = w_busy & ~wr_q;
  assign ramWEN   = w_busy &  wr_q;
  assign ramaddr  = w_busy ? addr_q  : '0;
  assign ramstore = w_busy ? wdata_q : '0;

  // Requester side: read data passes straight through in the completion cycle.
  assign iload = w_i_done ? ramload : '0;
  assign dload = w_d_done ? ramload : '0;
  assign iwait = iREN   & ~(w_in_instr & w_last);
  assign dwait = w_dreq & ~(w_in_data  & w_last);

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_arbiter
//  Purpose  : Self-checking bench for memory_arbiter. Directed scenarios plus
//             randomized request traffic compared every cycle against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;

  memory_arbiter #(.LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the access in flight is one record that counts down the
  // cycles it still needs. kind 0 = none, 1 = data, 2 = fetch.
  // --------------------------------------------------------------------------
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          write;
    int          left;
  } acc_t;

  acc_t cur;
  int   streak;

  function automatic bit m_live();
    return nRST && (cur.kind != 0);
  endfunction

  function automatic bit m_ends();
    bit want;
    want = (cur.kind == 1) ? (dREN || dWEN) : iREN;
    return m_live() && (cur.left == 1) && want;
  endfunction

  task automatic model_check();
    bit live;
    bit ends;
    live = m_live();
    ends = m_ends();
    check_eq("ramREN",   ramREN,   (live && !cur.write) ? 32'd1 : 32'd0);
    check_eq("ramWEN",   ramWEN,   (live &&  cur.write) ? 32'd1 : 32'd0);
    check_eq("ramaddr",  ramaddr,  live ? cur.addr  : 32'd0);
    check_eq("ramstore", ramstore, live ? cur.wdata : 32'd0);
    check_eq("iload",    iload,    (ends && cur.kind == 2) ? ramload : 32'd0);
    check_eq("dload",    dload,    (ends && cur.kind == 1) ? ramload : 32'd0);
    check_eq("iwait",    iwait,    (iREN && !(ends && cur.kind == 2)) ? 32'd1 : 32'd0);
    check_eq("dwait",    dwait,    ((dREN || dWEN) && !(ends && cur.kind == 1)) ? 32'd1 : 32'd0);
  endtask

  task automatic model_step();
    bit live;
    bit ends;
    bit want;
    if (!nRST) begin
      cur    = '{0, 32'd0, 32'd0, 1'b0, 0};
      streak = 0;
      return;
    end
    live = m_live();
    ends = m_ends();
    want = (cur.kind == 1) ? (dREN || dWEN) : iREN;
    if (!iREN || (ends && cur.kind == 2)) streak = 0;
    else if (ends && cur.kind == 1 && streak < SMAX) streak = streak + 1;
    if (!live || ends || !want) begin
      if ((dREN || dWEN) && !(iREN && streak == SMAX))
        cur = '{1, daddr, dstore, dWEN, LAT};
      else if (iREN)
        cur = '{2, iaddr, 32'd0, 1'b0, LAT};
      else
        cur = '{0, 32'd0, 32'd0, 1'b0, 0};
    end else begin
      cur.left = cur.left - 1;
    end
  endtask

  // Inputs are set just after a falling edge; checks land before the rising edge.
  task automatic tick();
    #2;
    model_check();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic go_idle();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    tick();
    tick();
  endtask

  int seq[$];
  int churn;
  int p;

  initial begin
    cur    = '{0, 32'd0, 32'd0, 1'b0, 0};
    streak = 0;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    @(negedge CLK);

    // Reset held with both requests pending.
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; iaddr = 32'h40;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("rst_ramREN", ramREN, 32'd0);
      check_eq("rst_ramWEN", ramWEN, 32'd0);
      check_eq("rst_iwait",  iwait,  32'd1);
      check_eq("rst_dwait",  dwait,  32'd1);
      tick();
    end
    nRST = 1'b1;
    tick();
    #1;
    check_eq("rst_rel_ramREN",  ramREN,  32'd1);
    check_eq("rst_rel_ramaddr", ramaddr, 32'h200);
    go_idle();

    // Single fetch.
    iREN = 1'b1; iaddr = 32'h40; ramload = 32'h8C010004;
    #1; check_eq("fetch_c0_ramREN", ramREN, 32'd0);
    tick();
    #1;
    check_eq("fetch_c1_ramREN",  ramREN,  32'd1);
    check_eq("fetch_c1_ramaddr", ramaddr, 32'h40);
    check_eq("fetch_c1_iwait",   iwait,   32'd1);
    tick();
    #1;
    check_eq("fetch_c2_ramaddr", ramaddr, 32'h40);
    check_eq("fetch_c2_iwait",   iwait,   32'd0);
    check_eq("fetch_c2_iload",   iload,   32'h8C010004);
    tick();
    go_idle();

    // Write priority over a simultaneous fetch.
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    tick();
    #1;
    check_eq("wpri_c1_ramWEN",   ramWEN,   32'd1);
    check_eq("wpri_c1_ramREN",   ramREN,   32'd0);
    check_eq("wpri_c1_ramaddr",  ramaddr,  32'h100);
    check_eq("wpri_c1_ramstore", ramstore, 32'hDEADBEEF);
    check_eq("wpri_c1_dwait",    dwait,    32'd1);
    tick();
    #1;
    check_eq("wpri_c2_dwait", dwait, 32'd0);
    check_eq("wpri_c2_iwait", iwait, 32'd1);
    tick();
    dWEN = 1'b0;
    tick();
    #1;
    check_eq("wpri_instr_ramREN",  ramREN,  32'd1);
    check_eq("wpri_instr_ramaddr", ramaddr, 32'h80);
    tick();
    #1; check_eq("wpri_instr_iwait", iwait, 32'd0);
    tick();
    go_idle();

    // Starvation guard: record the completion order with both held high.
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h44; daddr = 32'h300;
    for (int k = 0; k < 40 && seq.size() < 10; k++) begin
      #1;
      if (dREN && !dwait) seq.push_back(1);
      if (iREN && !iwait) seq.push_back(2);
      tick();
    end
    check_eq("starve_count", seq.size(), 32'd10);
    for (int k = 0; k < 10 && k < seq.size(); k++)
      check_eq($sformatf("starve_order%0d", k), seq[k], (k % 5 == 4) ? 32'd2 : 32'd1);
    go_idle();

    // Withdrawal: data dropped in its first cycle, fetch takes over.
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h44; daddr = 32'h300; ramload = 32'h11112222;
    tick();
    dREN = 1'b0;
    #1;
    check_eq("wd_dload",   dload,   32'd0);
    check_eq("wd_ramaddr", ramaddr, 32'h300);
    tick();
    #1;
    check_eq("wd_instr_ramaddr", ramaddr, 32'h44);
    check_eq("wd_instr_ramREN",  ramREN,  32'd1);
    tick();
    go_idle();

    // Read/write conflict, then reset in the first access cycle.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h500; dstore = 32'h1234;
    tick();
    #1;
    check_eq("rw_ramWEN", ramWEN, 32'd1);
    check_eq("rw_ramREN", ramREN, 32'd0);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    check_eq("rw_rst_ramWEN", ramWEN, 32'd0);
    check_eq("rw_rst_ramREN", ramREN, 32'd0);
    check_eq("rw_rst_dwait",  dwait,  32'd1);
    check_eq("rw_rst_dload",  dload,  32'd0);
    tick();
    go_idle();

    // Randomized traffic against the model.
    churn = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) churn = int'($urandom_range(0, 1));
      p = (churn != 0) ? 4 : 32;
      if ($urandom_range(0, p - 1) == 0)     iREN = ~iREN;
      if ($urandom_range(0, p - 1) == 0)     dREN = ~dREN;
      if ($urandom_range(0, 2 * p - 1) == 0) dWEN = ~dWEN;
      if ($urandom_range(0, 7) == 0) iaddr  = $urandom;
      if ($urandom_range(0, 7) == 0) daddr  = $urandom;
      if ($urandom_range(0, 7) == 0) dstore = $urandom;
      ramload = $urandom;
      nRST = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
